// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: forwarding, stalls, flushes.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32,
    parameter logic [1:0]  LOAD_SRC = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] Rd_D,
    input  logic              regWrite_D,
    input  logic [1:0]        resultSrc_D,
    input  logic              pcSrc_E,
    input  logic              mem_busy,
    output logic              stall_F,
    output logic              stall_D,
    output logic              freeze_EM,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_W,
    output logic [1:0]        forwardA_E,
    output logic [1:0]        forwardB_E,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mb_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } ent_e_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } ent_t;

    ent_e_t e_q, e_d;
    ent_t   m_q, m_d;
    ent_t   w_q, w_d;

    logic busy;
    logic lw_stall;
    logic m_wr;
    logic w_wr;

    // Qualify hazards; a busy memory cannot assert stalls while in reset
    always_comb begin
        busy     = mem_busy & rst_n;
        lw_stall = e_q.valid & e_q.is_load & (e_q.rd != '0)
                 & ((e_q.rd == rs1_D) | (e_q.rd == rs2_D));
        m_wr     = m_q.valid & m_q.reg_write & (m_q.rd != '0);
        w_wr     = w_q.valid & w_q.reg_write & (w_q.rd != '0);
    end

    // Prioritised stall/flush: freeze, then branch, then load-use
    always_comb begin
        stall_F   = 1'b0;
        stall_D   = 1'b0;
        freeze_EM = 1'b0;
        flush_D   = 1'b0;
        flush_E   = 1'b0;
        flush_W   = 1'b0;
        if (busy) begin
            stall_F   = 1'b1;
            stall_D   = 1'b1;
            freeze_EM = 1'b1;
            flush_W   = 1'b1;
        end else if (pcSrc_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (lw_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    // Operand forwarding selects, M stage wins over W stage
    always_comb begin
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        if (m_wr && (m_q.rd == e_q.rs1)) begin
            forwardA_E = 2'b10;
        end else if (w_wr && (w_q.rd == e_q.rs1)) begin
            forwardA_E = 2'b01;
        end
        if (m_wr && (m_q.rd == e_q.rs2)) begin
            forwardB_E = 2'b10;
        end else if (w_wr && (w_q.rd == e_q.rs2)) begin
            forwardB_E = 2'b01;
        end
    end

    // Shadow pipeline advance; freeze holds E/M and bubbles W
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (busy) begin
            w_d = '0;
        end else begin
            w_d           = m_q;
            m_d.valid     = e_q.valid;
            m_d.rd        = e_q.rd;
            m_d.reg_write = e_q.reg_write;
            if (flush_E) begin
                e_d = '0;
            end else begin
                e_d.valid     = 1'b1;
                e_d.rs1       = rs1_D;
                e_d.rs2       = rs2_D;
                e_d.rd        = Rd_D;
                e_d.reg_write = regWrite_D;
                e_d.is_load   = (resultSrc_D == LOAD_SRC);
            end
        end
    end

    // Shadow state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mb_cnt_q, mb_cnt_d;
    logic             lu_inc;
    logic             br_inc;

    // Saturating event counters
    always_comb begin
        lu_inc   = lw_stall & ~busy & ~pcSrc_E;
        br_inc   = pcSrc_E & ~busy;
        lu_cnt_d = lu_cnt_q;
        br_cnt_d = br_cnt_q;
        mb_cnt_d = mb_cnt_q;
        if (lu_inc && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        end
        if (br_inc && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (busy && (mb_cnt_q != '1)) begin
            mb_cnt_d = mb_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            br_cnt_q <= '0;
            mb_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            br_cnt_q <= br_cnt_d;
            mb_cnt_q <= mb_cnt_d;
        end
    end

    assign lu_cnt = lu_cnt_q;
    assign br_cnt = br_cnt_q;
    assign mb_cnt = mb_cnt_q;
`else
    assign lu_cnt = '0;
    assign br_cnt = '0;
    assign mb_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_D, rs2_D, Rd_D;
    logic        regWrite_D;
    logic [1:0]  resultSrc_D;
    logic        pcSrc_E;
    logic        mem_busy;
    logic        stall_F, stall_D, freeze_EM;
    logic        flush_D, flush_E, flush_W;
    logic [1:0]  forwardA_E, forwardB_E;
    logic [31:0] lu_cnt, br_cnt, mb_cnt;
    logic [5:0]  ctl;

    int checks = 0;
    int fails  = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .Rd_D(Rd_D),
        .regWrite_D(regWrite_D), .resultSrc_D(resultSrc_D),
        .pcSrc_E(pcSrc_E), .mem_busy(mem_busy),
        .stall_F(stall_F), .stall_D(stall_D), .freeze_EM(freeze_EM),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .lu_cnt(lu_cnt), .br_cnt(br_cnt), .mb_cnt(mb_cnt)
    );

    always #5 clk = ~clk;

    // {stall_F, stall_D, freeze_EM, flush_D, flush_E, flush_W}
    assign ctl = {stall_F, stall_D, freeze_EM, flush_D, flush_E, flush_W};

    task automatic drive(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic rw,
                         input logic [1:0] src);
        rs1_D = a; rs2_D = b; Rd_D = d;
        regWrite_D = rw; resultSrc_D = src;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pcSrc_E = 1'b0;
        mem_busy = 1'b0;
        nop();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pcSrc_E = 1'b0;
        mem_busy = 1'b0;
        nop();
        settle();
        checks++;
        if (ctl !== 6'b000000) begin
            $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); fails++;
        end
        checks++;
        if ({forwardA_E, forwardB_E} !== 4'b0000) begin
            $display("FAIL reset_fwd: got %b expected %b", {forwardA_E, forwardB_E}, 4'b0000); fails++;
        end
        checks++;
        if ({lu_cnt, br_cnt, mb_cnt} !== 96'd0) begin
            $display("FAIL reset_cnt: got %0h/%0h/%0h expected 0", lu_cnt, br_cnt, mb_cnt); fails++;
        end
        pcSrc_E = 1'b1;
        #1;
        checks++;
        if (ctl !== 6'b000110) begin
            $display("FAIL reset_pcsrc: got %b expected %b", ctl, 6'b000110); fails++;
        end
        pcSrc_E = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd2, 5'd0, 5'd5, 1'b1, 2'b01);
        settle();
        checks++;
        if (ctl !== 6'b000000) begin
            $display("FAIL lu_pre: got %b expected %b", ctl, 6'b000000); fails++;
        end
        tick();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        settle();
        checks++;
        if (ctl !== 6'b110010) begin
            $display("FAIL lu_stall: got %b expected %b", ctl, 6'b110010); fails++;
        end
        tick();
        settle();
        checks++;
        if (ctl !== 6'b000000 || forwardA_E !== 2'b00) begin
            $display("FAIL lu_bubble: got ctl %b fa %b expected 000000 00", ctl, forwardA_E); fails++;
        end
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b01 || forwardB_E !== 2'b00) begin
            $display("FAIL lu_fwd: got %b/%b expected 01/00", forwardA_E, forwardB_E); fails++;
        end
        checks++;
        if (lu_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            $display("FAIL lu_cnt: got %0d expected %0d", lu_cnt, PERF ? 1 : 0); fails++;
        end
        tick();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive(5'd0, 5'd5, 5'd3, 1'b1, 2'b00);
        tick();
        drive(5'd3, 5'd3, 5'd4, 1'b1, 2'b00);
        settle();
        checks++;
        if (ctl !== 6'b000000) begin
            $display("FAIL alu_nostall: got %b expected %b", ctl, 6'b000000); fails++;
        end
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b10 || forwardB_E !== 2'b10) begin
            $display("FAIL alu_fwd_m: got %b/%b expected 10/10", forwardA_E, forwardB_E); fails++;
        end
        do_reset();
        drive(5'd0, 5'd5, 5'd3, 1'b1, 2'b00);
        tick();
        nop();
        tick();
        drive(5'd3, 5'd3, 5'd4, 1'b1, 2'b00);
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b01 || forwardB_E !== 2'b01) begin
            $display("FAIL alu_fwd_w: got %b/%b expected 01/01", forwardA_E, forwardB_E); fails++;
        end
        do_reset();
        drive(5'd0, 5'd5, 5'd3, 1'b1, 2'b00);
        tick();
        drive(5'd0, 5'd7, 5'd3, 1'b1, 2'b00);
        tick();
        drive(5'd3, 5'd3, 5'd4, 1'b1, 2'b00);
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b10 || forwardB_E !== 2'b10) begin
            $display("FAIL alu_m_prio: got %b/%b expected 10/10", forwardA_E, forwardB_E); fails++;
        end
        do_reset();
        drive(5'd0, 5'd0, 5'd3, 1'b0, 2'b00);
        tick();
        drive(5'd3, 5'd0, 5'd4, 1'b1, 2'b00);
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b00) begin
            $display("FAIL alu_nowrite: got %b expected 00", forwardA_E); fails++;
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        drive(5'd0, 5'd1, 5'd0, 1'b1, 2'b00);
        tick();
        drive(5'd0, 5'd0, 5'd1, 1'b1, 2'b00);
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b00 || forwardB_E !== 2'b00) begin
            $display("FAIL x0_fwd: got %b/%b expected 00/00", forwardA_E, forwardB_E); fails++;
        end
        do_reset();
        drive(5'd2, 5'd0, 5'd0, 1'b1, 2'b01);
        tick();
        drive(5'd0, 5'd0, 5'd1, 1'b1, 2'b00);
        settle();
        checks++;
        if (ctl !== 6'b000000) begin
            $display("FAIL x0_nostall: got %b expected %b", ctl, 6'b000000); fails++;
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive(5'd2, 5'd0, 5'd5, 1'b1, 2'b01);
        tick();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        pcSrc_E = 1'b1;
        settle();
        checks++;
        if (ctl !== 6'b000110) begin
            $display("FAIL br_flush: got %b expected %b", ctl, 6'b000110); fails++;
        end
        tick();
        pcSrc_E = 1'b0;
        nop();
        settle();
        checks++;
        if (ctl !== 6'b000000) begin
            $display("FAIL br_after: got %b expected %b", ctl, 6'b000000); fails++;
        end
        checks++;
        if (br_cnt !== (PERF ? 32'd1 : 32'd0) || lu_cnt !== 32'd0) begin
            $display("FAIL br_cnt: got br %0d lu %0d expected br %0d lu 0", br_cnt, lu_cnt, PERF ? 1 : 0); fails++;
        end
        tick();
    endtask

    task automatic test_mem_busy();
        do_reset();
        drive(5'd0, 5'd5, 5'd7, 1'b1, 2'b00);
        tick();
        drive(5'd7, 5'd7, 5'd8, 1'b1, 2'b00);
        tick();
        drive(5'd7, 5'd8, 5'd9, 1'b1, 2'b00);
        settle();
        checks++;
        if (forwardA_E !== 2'b10 || forwardB_E !== 2'b10) begin
            $display("FAIL mb_pre_fwd: got %b/%b expected 10/10", forwardA_E, forwardB_E); fails++;
        end
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pcSrc_E = (i == 1);
            settle();
            checks++;
            if (ctl !== 6'b111001) begin
                $display("FAIL mb_freeze%0d: got %b expected %b", i, ctl, 6'b111001); fails++;
            end
            checks++;
            if (forwardA_E !== 2'b10 || forwardB_E !== 2'b10) begin
                $display("FAIL mb_hold_fwd%0d: got %b/%b expected 10/10", i, forwardA_E, forwardB_E); fails++;
            end
            tick();
        end
        mem_busy = 1'b0;
        pcSrc_E = 1'b0;
        settle();
        checks++;
        if (ctl !== 6'b000000 || forwardA_E !== 2'b10) begin
            $display("FAIL mb_release: got ctl %b fa %b expected 000000 10", ctl, forwardA_E); fails++;
        end
        checks++;
        if (mb_cnt !== (PERF ? 32'd3 : 32'd0) || br_cnt !== 32'd0) begin
            $display("FAIL mb_cnt: got mb %0d br %0d expected mb %0d br 0", mb_cnt, br_cnt, PERF ? 3 : 0); fails++;
        end
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b01 || forwardB_E !== 2'b10) begin
            $display("FAIL mb_resume: got %b/%b expected 01/10", forwardA_E, forwardB_E); fails++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(5'd2, 5'd0, 5'd5, 1'b1, 2'b01);
        tick();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        settle();
        checks++;
        if (ctl !== 6'b110010) begin
            $display("FAIL rm_stall: got %b expected %b", ctl, 6'b110010); fails++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== 6'b000000 || {forwardA_E, forwardB_E} !== 4'b0000) begin
            $display("FAIL rm_async: got ctl %b fwd %b expected 000000 0000", ctl, {forwardA_E, forwardB_E}); fails++;
        end
        checks++;
        if (lu_cnt !== 32'd0) begin
            $display("FAIL rm_cnt: got %0d expected 0", lu_cnt); fails++;
        end
        pcSrc_E = 1'b1;
        #1;
        checks++;
        if (ctl !== 6'b000110) begin
            $display("FAIL rm_pcsrc: got %b expected %b", ctl, 6'b000110); fails++;
        end
        pcSrc_E = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        settle();
        checks++;
        if (ctl !== 6'b000000) begin
            $display("FAIL rm_first: got %b expected %b", ctl, 6'b000000); fails++;
        end
        tick();
        nop();
        settle();
        checks++;
        if (forwardA_E !== 2'b00 || forwardB_E !== 2'b00) begin
            $display("FAIL rm_fwd: got %b/%b expected 00/00", forwardA_E, forwardB_E); fails++;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_x0();
        test_branch();
        test_mem_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
